// File: rtl/snake_body_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// snake_body_ctrl_pkg
// Shared definitions for the snake movement engine: playfield geometry,
// heading codes, FSM state encoding, the segment cell type and the
// cell-to-pixel conversion used for head position and apple matching.
// -----------------------------------------------------------------------------
package snake_body_ctrl_pkg;

    localparam int GRID_W   = 32;   // cells, x = 0..31
    localparam int GRID_H   = 24;   // cells, y = 0..23
    localparam int CELL_PX  = 20;   // pixels per cell
    localparam int MAX_LEN  = 64;   // segment buffer depth (power of two, pointers wrap)
    localparam int INIT_LEN = 3;    // body length after reset

    localparam logic [4:0] START_X = 5'd16;
    localparam logic [4:0] START_Y = 5'd12;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_CHECK,
        ST_COMMIT,
        ST_DEAD
    } state_t;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } cell_t;

    // Pixel coordinate of a cell, truncated to the 10-bit pixel bus.
    function automatic logic [9:0] cell_to_px(input logic [4:0] c);
        logic [9:0] wide;
        wide = {5'b0, c};
        return wide * 10'(CELL_PX);
    endfunction

    // Opposite headings differ only in bit 1 (up/down, right/left).
    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a ^ b) == 2'd2;
    endfunction

endpackage

// File: rtl/snake_body_ctrl_seg_buf.sv
// -----------------------------------------------------------------------------
// snake_seg_buf
// Circular buffer of snake segments. Segment i lives at head_ptr + i, so a
// push writes one slot below the head and a pop simply shrinks the count.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (loads initial body)
//   push_head/push_cell new head entry
//   pop_tail            retire the tail (may coincide with push_head)
//   rd_idx -> rd_data   registered read, index relative to head
//   rd_valid            registered (rd_idx < count)
//   chk_idx -> chk_data combinational read for the collision scan
//   count               current number of segments
// -----------------------------------------------------------------------------
module snake_seg_buf
    import snake_body_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_head,
    input  cell_t      push_cell,
    input  logic       pop_tail,
    input  logic [5:0] rd_idx,
    output cell_t      rd_data,
    output logic       rd_valid,
    input  logic [5:0] chk_idx,
    output cell_t      chk_data,
    output logic [6:0] count
);

    cell_t      mem [MAX_LEN];
    logic [5:0] head_ptr;
    logic [5:0] rd_addr;
    logic [5:0] chk_addr;

    // 6-bit adds wrap modulo MAX_LEN, which is exactly the ring addressing.
    assign rd_addr  = head_ptr + rd_idx;
    assign chk_addr = head_ptr + chk_idx;
    assign chk_data = mem[chk_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_ptr <= '0;
            count    <= 7'(INIT_LEN);
            // NOTE: the body storage is reset on purpose: reset must restore the
            // initial snake, so this array is built from flops, not a RAM macro.
            for (int i = 0; i < MAX_LEN; i++) begin
                mem[i] <= (i < INIT_LEN) ? cell_t'{x: START_X - 5'(i), y: START_Y}
                                         : cell_t'('0);
            end
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            // When full and not growing, the new head slot is the old tail slot,
            // which is the one being retired in the same cycle.
            if (push_head) begin
                mem[head_ptr - 6'd1] <= push_cell;
                head_ptr             <= head_ptr - 6'd1;
            end
            case ({push_head, pop_tail})
                2'b10:   count <= count + 7'd1;
                2'b01:   count <= count - 7'd1;
                default: count <= count;
            endcase
            // Reads sample pre-update contents, so a read during a push sees
            // the body as it was before the commit.
            rd_data  <= mem[rd_addr];
            rd_valid <= {1'b0, rd_idx} < count;
        end
    end

endmodule

// File: rtl/snake_body_ctrl.sv
// -----------------------------------------------------------------------------
// snake_body_ctrl
// Snake movement engine: one step per move_tick. Computes the next head,
// detects wall hits, apple hits (growth) and self hits (one segment per
// cycle), then commits the new head into the segment buffer.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   move_tick, dir_req    step request and requested heading
//   applex, appley        apple position in pixels
//   newposx, newposy      head position in pixels (registered)
//   len                   current length
//   busy, ate, game_over  status: step in progress, grew this step, dead
//   rd_idx -> rd_x/rd_y   renderer read port, 1-cycle latency, with rd_valid
// -----------------------------------------------------------------------------
module snake_body_ctrl
    import snake_body_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       move_tick,
    input  logic [1:0] dir_req,
    input  logic [9:0] applex,
    input  logic [9:0] appley,
    output logic [9:0] newposx,
    output logic [9:0] newposy,
    output logic [6:0] len,
    output logic       busy,
    output logic       ate,
    output logic       game_over,
    input  logic [5:0] rd_idx,
    output logic [4:0] rd_x,
    output logic [4:0] rd_y,
    output logic       rd_valid
);

    localparam logic signed [5:0] X_MAX = 6'(GRID_W - 1);
    localparam logic signed [5:0] Y_MAX = 6'(GRID_H - 1);

    state_t     state;
    dir_t       heading;
    cell_t      head;
    cell_t      next_head;
    logic       grow;
    logic [5:0] chk_idx;
    logic [6:0] chk_n;

    logic signed [5:0] dx, dy, nx, ny;
    logic       off_grid;
    logic       grow_calc;
    cell_t      chk_data;
    cell_t      rd_data;
    logic       push_head;
    logic       pop_tail;

    // Next-head arithmetic in 6-bit signed so stepping off either edge is
    // visible as a negative value or a value beyond the grid.
    always_comb begin
        // NOTE: combinational outputs get a default first so no path leaves
        // them unassigned and infers a latch.
        dx = '0;
        dy = '0;
        case (heading)
            DIR_UP:    dy = -6'sd1;
            DIR_RIGHT: dx =  6'sd1;
            DIR_DOWN:  dy =  6'sd1;
            DIR_LEFT:  dx = -6'sd1;
            default: ;
        endcase
        nx        = $signed({1'b0, head.x}) + dx;
        ny        = $signed({1'b0, head.y}) + dy;
        off_grid  = (nx < 6'sd0) || (nx > X_MAX) || (ny < 6'sd0) || (ny > Y_MAX);
        // A full snake cannot grow; it just moves.
        grow_calc = (cell_to_px(nx[4:0]) == applex) && (cell_to_px(ny[4:0]) == appley)
                    && (len != 7'(MAX_LEN));
    end

    assign push_head = (state == ST_COMMIT);
    assign pop_tail  = push_head && !grow;
    assign busy      = (state != ST_IDLE);
    assign rd_x      = rd_data.x;
    assign rd_y      = rd_data.y;

    snake_seg_buf u_seg_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_head (push_head),
        .push_cell (next_head),
        .pop_tail  (pop_tail),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .chk_idx   (chk_idx),
        .chk_data  (chk_data),
        .count     (len)
    );

    // NOTE: all state below is sequential and uses non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            heading   <= DIR_RIGHT;
            head      <= cell_t'{x: START_X, y: START_Y};
            next_head <= '0;
            grow      <= 1'b0;
            chk_idx   <= '0;
            chk_n     <= '0;
            newposx   <= cell_to_px(START_X);
            newposy   <= cell_to_px(START_Y);
            ate       <= 1'b0;
            game_over <= 1'b0;
        end else begin
            ate <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (move_tick) begin
                        if (!is_reverse(dir_t'(dir_req), heading))
                            heading <= dir_t'(dir_req);
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (off_grid) begin
                        state <= ST_DEAD;
                    end else begin
                        next_head <= cell_t'{x: nx[4:0], y: ny[4:0]};
                        grow      <= grow_calc;
                        // Without growth the tail moves away this step, so it
                        // is excluded from the scan. len >= 2 keeps this >= 1.
                        chk_n     <= grow_calc ? len : len - 7'd1;
                        chk_idx   <= '0;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (chk_data == next_head)
                        state <= ST_DEAD;
                    else if ({1'b0, chk_idx} == chk_n - 7'd1)
                        state <= ST_COMMIT;
                    else
                        chk_idx <= chk_idx + 6'd1;
                end
                ST_COMMIT: begin
                    head    <= next_head;
                    newposx <= cell_to_px(next_head.x);
                    newposy <= cell_to_px(next_head.y);
                    ate     <= grow;
                    state   <= ST_IDLE;
                end
                ST_DEAD: begin
                    game_over <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_ctrl.sv
module tb_snake_body_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_tick;
    logic [1:0] dir_req;
    logic [9:0] applex, appley;
    logic [9:0] newposx, newposy;
    logic [6:0] len;
    logic       busy, ate, game_over;
    logic [5:0] rd_idx;
    logic [4:0] rd_x, rd_y;
    logic       rd_valid;

    int total = 0;
    int bad   = 0;

    snake_body_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .move_tick (move_tick),
        .dir_req   (dir_req),
        .applex    (applex),
        .appley    (appley),
        .newposx   (newposx),
        .newposy   (newposy),
        .len       (len),
        .busy      (busy),
        .ate       (ate),
        .game_over (game_over),
        .rd_idx    (rd_idx),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .rd_valid  (rd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst_n     = 1'b0;
        move_tick = 1'b0;
        dir_req   = 2'd1;
        applex    = 10'd1023;
        appley    = 10'd1023;
        rd_idx    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One step; returns number of cycles ate was seen high until the step ends.
    task automatic do_tick(input logic [1:0] d, output int ate_cnt);
        int c;
        dir_req   = d;
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        ate_cnt   = 0;
        for (c = 0; c < 100; c++) begin
            if (ate === 1'b1) ate_cnt++;
            if (busy === 1'b0 || game_over === 1'b1) break;
            @(negedge clk);
        end
        total++; if (c >= 100) begin bad++; $display("FAIL tick_timeout got=%0d cycles exp<100", c); end
    endtask

    task automatic read_seg(input logic [5:0] idx, output logic [4:0] x, output logic [4:0] y, output logic v);
        rd_idx = idx;
        @(negedge clk);
        x = rd_x;
        y = rd_y;
        v = rd_valid;
    endtask

    task automatic test_reset();
        logic [4:0] x, y;
        logic       v;
        rst_n = 1'b0; move_tick = 1'b0; dir_req = 2'd1; applex = 10'd1023; appley = 10'd1023; rd_idx = '0;
        repeat (2) @(negedge clk);
        total++; if (newposx !== 10'd320) begin bad++; $display("FAIL reset_posx got=%0d exp=320", newposx); end
        total++; if (newposy !== 10'd240) begin bad++; $display("FAIL reset_posy got=%0d exp=240", newposy); end
        total++; if (len !== 7'd3) begin bad++; $display("FAIL reset_len got=%0d exp=3", len); end
        total++; if ({busy, ate, game_over} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {busy, ate, game_over}); end
        total++; if ({rd_x, rd_y, rd_valid} !== 11'd0) begin bad++; $display("FAIL reset_rdport got=%0d/%0d/%0d exp=0/0/0", rd_x, rd_y, rd_valid); end
        rst_n = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            read_seg(6'(i), x, y, v);
            if (i < 3) begin
                total++; if ({x, y, v} !== {5'(16 - i), 5'd12, 1'b1}) begin bad++; $display("FAIL reset_seg%0d got=(%0d,%0d,v%0d) exp=(%0d,12,v1)", i, x, y, v, 16 - i); end
            end else begin
                total++; if (v !== 1'b0) begin bad++; $display("FAIL reset_valid_at_len got=%0d exp=0", v); end
            end
        end
    endtask

    task automatic test_step_latency();
        logic [4:0] x, y;
        logic       v;
        apply_reset();
        dir_req = 2'd1; move_tick = 1'b1;
        @(negedge clk);            // edge T has sampled the tick
        move_tick = 1'b0;
        repeat (3) @(negedge clk); // after T+3
        total++; if ({newposx, busy} !== {10'd320, 1'b1}) begin bad++; $display("FAIL step_early got=%0d busy=%0d exp=320 busy=1", newposx, busy); end
        @(negedge clk);            // after T+4
        total++; if (newposx !== 10'd340 || newposy !== 10'd240) begin bad++; $display("FAIL step_pos got=(%0d,%0d) exp=(340,240)", newposx, newposy); end
        total++; if ({busy, len} !== {1'b0, 7'd3}) begin bad++; $display("FAIL step_idle_len got=busy%0d len%0d exp=busy0 len3", busy, len); end
        read_seg(6'd2, x, y, v);
        total++; if ({x, y, v} !== {5'd15, 5'd12, 1'b1}) begin bad++; $display("FAIL step_seg2 got=(%0d,%0d,v%0d) exp=(15,12,v1)", x, y, v); end
    endtask

    task automatic test_reverse();
        int a;
        apply_reset();
        do_tick(2'd1, a);
        do_tick(2'd3, a);  // reverse request, ignored
        total++; if (newposx !== 10'd360 || newposy !== 10'd240) begin bad++; $display("FAIL reverse_pos got=(%0d,%0d) exp=(360,240)", newposx, newposy); end
        do_tick(2'd2, a);  // legal turn down
        total++; if (newposx !== 10'd360 || newposy !== 10'd260) begin bad++; $display("FAIL turn_down_pos got=(%0d,%0d) exp=(360,260)", newposx, newposy); end
    endtask

    task automatic test_grow();
        int a;
        logic [4:0] x, y;
        logic       v;
        apply_reset();
        applex = 10'd360; appley = 10'd240;
        do_tick(2'd1, a);
        total++; if (a !== 0 || len !== 7'd3) begin bad++; $display("FAIL grow_first got=ate%0d len%0d exp=ate0 len3", a, len); end
        do_tick(2'd1, a);
        total++; if (a !== 1 || len !== 7'd4) begin bad++; $display("FAIL grow_second got=ate%0d len%0d exp=ate1 len4", a, len); end
        @(negedge clk);
        total++; if (ate !== 1'b0) begin bad++; $display("FAIL grow_ate_width got=%0d exp=0", ate); end
        read_seg(6'd3, x, y, v);
        total++; if ({x, y, v} !== {5'd15, 5'd12, 1'b1}) begin bad++; $display("FAIL grow_tail got=(%0d,%0d,v%0d) exp=(15,12,v1)", x, y, v); end
        read_seg(6'd4, x, y, v);
        total++; if (v !== 1'b0) begin bad++; $display("FAIL grow_valid_at_len got=%0d exp=0", v); end
    endtask

    task automatic test_wall();
        int a;
        apply_reset();
        for (int i = 0; i < 15; i++) do_tick(2'd1, a);
        total++; if (newposx !== 10'd620 || game_over !== 1'b0) begin bad++; $display("FAIL wall_approach got=x%0d go%0d exp=x620 go0", newposx, game_over); end
        dir_req = 2'd1; move_tick = 1'b1;
        @(negedge clk);            // edge T
        move_tick = 1'b0;
        repeat (2) @(negedge clk); // after T+2
        total++; if (game_over !== 1'b1) begin bad++; $display("FAIL wall_game_over got=%0d exp=1", game_over); end
        do_tick(2'd0, a);
        repeat (6) @(negedge clk);
        total++; if ({newposx, newposy, len} !== {10'd620, 10'd240, 7'd3}) begin bad++; $display("FAIL wall_frozen got=(%0d,%0d) len%0d exp=(620,240) len3", newposx, newposy, len); end
        total++; if ({game_over, busy} !== 2'b11) begin bad++; $display("FAIL wall_sticky got=go%0d busy%0d exp=go1 busy1", game_over, busy); end
    endtask

    task automatic test_self_hit();
        int a;
        apply_reset();
        applex = 10'd340; appley = 10'd240;
        do_tick(2'd1, a);
        applex = 10'd360;
        do_tick(2'd1, a);
        applex = 10'd1023; appley = 10'd1023;
        total++; if (len !== 7'd5) begin bad++; $display("FAIL self_grown_len got=%0d exp=5", len); end
        do_tick(2'd0, a);
        do_tick(2'd3, a);
        total++; if ({game_over, newposx, newposy} !== {1'b0, 10'd340, 10'd220}) begin bad++; $display("FAIL self_pre got=go%0d (%0d,%0d) exp=go0 (340,220)", game_over, newposx, newposy); end
        do_tick(2'd2, a);
        repeat (2) @(negedge clk);
        total++; if ({game_over, len} !== {1'b1, 7'd5}) begin bad++; $display("FAIL self_hit got=go%0d len%0d exp=go1 len5", game_over, len); end
        total++; if (newposx !== 10'd340 || newposy !== 10'd220) begin bad++; $display("FAIL self_hit_pos got=(%0d,%0d) exp=(340,220)", newposx, newposy); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] x, y;
        logic       v;
        apply_reset();
        dir_req = 2'd1; move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        @(negedge clk);
        move_tick = 1'b1;          // arrives while busy, must be dropped
        @(negedge clk);
        move_tick = 1'b0;
        repeat (10) @(negedge clk);
        total++; if ({newposx, busy, len} !== {10'd340, 1'b0, 7'd3}) begin bad++; $display("FAIL busy_drop got=x%0d busy%0d len%0d exp=x340 busy0 len3", newposx, busy, len); end
        // Abort a step in CHECK with reset.
        move_tick = 1'b1;
        @(negedge clk);            // edge T
        move_tick = 1'b0;
        repeat (2) @(negedge clk); // in CHECK after T+2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++; if ({newposx, newposy, len, busy, game_over} !== {10'd320, 10'd240, 7'd3, 1'b0, 1'b0}) begin bad++; $display("FAIL reset_mid_check got=(%0d,%0d) len%0d busy%0d go%0d exp=(320,240) len3 busy0 go0", newposx, newposy, len, busy, game_over); end
        read_seg(6'd0, x, y, v);
        total++; if ({x, y, v} !== {5'd16, 5'd12, 1'b1}) begin bad++; $display("FAIL reset_mid_check_head got=(%0d,%0d,v%0d) exp=(16,12,v1)", x, y, v); end
    endtask

    initial begin
        test_reset();
        test_step_latency();
        test_reverse();
        test_grow();
        test_wall();
        test_self_hit();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
